// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the CPU register bank.
// Each producer has one holding entry. Held entries are granted round-robin onto the
// bank's single registered write port. Decode-stage reads are checked against entries
// that have not yet been issued.
// Optional feature macro: WB_BYPASS_EN. When defined, a read that matches exactly one
// held entry is forwarded from that entry instead of stalling.
module regfile_wb_arbiter #(
   parameter int REG_NUM    = 32,
   parameter int DATA_WIDTH = 64,
   parameter int NUM_SRC    = 2,
   localparam int AW        = $clog2(REG_NUM),
   localparam int PW        = $clog2(NUM_SRC + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_SRC-1:0]             src_valid,
   output logic [NUM_SRC-1:0]             src_ready,
   input  logic [NUM_SRC*AW-1:0]          src_addr,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
   output logic                           rf_write_en,
   output logic [AW-1:0]                  rf_write_addr,
   output logic [DATA_WIDTH-1:0]          rf_data_in,
   input  logic [AW-1:0]                  rd_addr_a,
   input  logic [AW-1:0]                  rd_addr_b,
   output logic                           hazard_a,
   output logic                           hazard_b,
   output logic                           fwd_valid_a,
   output logic                           fwd_valid_b,
   output logic [DATA_WIDTH-1:0]          fwd_data_a,
   output logic [DATA_WIDTH-1:0]          fwd_data_b,
   output logic [PW-1:0]                  pending
);

   localparam int PTRW = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]    held;
   logic [AW-1:0]         h_addr [NUM_SRC];
   logic [DATA_WIDTH-1:0] h_data [NUM_SRC];
   logic [PTRW-1:0]       rr_ptr;
   logic                  gnt_vld;
   logic [PTRW-1:0]       gnt_idx;
   logic [NUM_SRC-1:0]    grant;
   logic [NUM_SRC-1:0]    match_a;
   logic [NUM_SRC-1:0]    match_b;
   logic [PW-1:0]         cnt_a;
   logic [PW-1:0]         cnt_b;

   // Round-robin pick: first held entry at or after the pointer.
   always_comb begin
      int idx;
      logic [PTRW-1:0] cand;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx  = (int'(rr_ptr) + k) % NUM_SRC;
         cand = PTRW'(idx);
         if (!gnt_vld && held[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_vld) grant[gnt_idx] = 1'b1;
   end

   // An entry being drained this cycle can be refilled in the same cycle.
   assign src_ready = ~held | grant;

   // Holding entries: load on accepted non-x0 writes, clear on grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         held <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            h_addr[i] <= '0;
            h_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               // x0 writes are swallowed; ready implies the entry ends up empty
               held[i] <= (src_addr[i*AW +: AW] != '0);
               if (src_addr[i*AW +: AW] != '0) begin
                  h_addr[i] <= src_addr[i*AW +: AW];
                  h_data[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end else if (grant[i]) begin
               held[i] <= 1'b0;
            end
         end
      end
   end

   // Pointer advances past the winner so every held source is served in turn.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (gnt_vld) begin
         rr_ptr <= (gnt_idx == PTRW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Registered bank write port; addr/data keep their last value when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_data_in    <= '0;
      end else begin
         rf_write_en <= gnt_vld;
         if (gnt_vld) begin
            rf_write_addr <= h_addr[gnt_idx];
            rf_data_in    <= h_data[gnt_idx];
         end
      end
   end

   // Occupancy and read-address matches against held entries (x0 never matches).
   always_comb begin
      pending = '0;
      cnt_a   = '0;
      cnt_b   = '0;
      match_a = '0;
      match_b = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pending    = pending + PW'(held[i]);
         match_a[i] = held[i] && (rd_addr_a != '0) && (h_addr[i] == rd_addr_a);
         match_b[i] = held[i] && (rd_addr_b != '0) && (h_addr[i] == rd_addr_b);
         cnt_a      = cnt_a + PW'(match_a[i]);
         cnt_b      = cnt_b + PW'(match_b[i]);
      end
   end

`ifdef WB_BYPASS_EN
   logic [DATA_WIDTH-1:0] hit_a;
   logic [DATA_WIDTH-1:0] hit_b;

   // Data of the matching entry; only meaningful when exactly one matches.
   always_comb begin
      hit_a = '0;
      hit_b = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (match_a[i]) hit_a = h_data[i];
         if (match_b[i]) hit_b = h_data[i];
      end
   end

   assign fwd_valid_a = (cnt_a == PW'(1));
   assign fwd_valid_b = (cnt_b == PW'(1));
   assign fwd_data_a  = fwd_valid_a ? hit_a : '0;
   assign fwd_data_b  = fwd_valid_b ? hit_b : '0;
   assign hazard_a    = (cnt_a > PW'(1));
   assign hazard_b    = (cnt_b > PW'(1));
`else
   assign fwd_valid_a = 1'b0;
   assign fwd_valid_b = 1'b0;
   assign fwd_data_a  = '0;
   assign fwd_data_b  = '0;
   assign hazard_a    = (cnt_a != '0);
   assign hazard_b    = (cnt_b != '0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-level reference model. Honours WB_BYPASS_EN like the design.
module tb_regfile_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int NS = 2;
   localparam int PW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NS-1:0]     src_valid;
   logic [NS-1:0]     src_ready;
   logic [NS*AW-1:0]  src_addr;
   logic [NS*DW-1:0]  src_data;
   logic              rf_write_en;
   logic [AW-1:0]     rf_write_addr;
   logic [DW-1:0]     rf_data_in;
   logic [AW-1:0]     rd_addr_a, rd_addr_b;
   logic              hazard_a, hazard_b, fwd_valid_a, fwd_valid_b;
   logic [DW-1:0]     fwd_data_a, fwd_data_b;
   logic [PW-1:0]     pending;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_wb_arbiter #(.REG_NUM(32), .DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_addr(src_addr), .src_data(src_data),
      .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .hazard_a(hazard_a), .hazard_b(hazard_b),
      .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // reference model: one slot per source plus the round-robin turn
   bit          m_held [NS];
   logic [AW-1:0] m_addr [NS];
   logic [DW-1:0] m_data [NS];
   int          m_turn;
   logic        m_en;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;

   task automatic drive_src(input int s, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      src_valid[s]          = v;
      src_addr[s*AW +: AW]  = a;
      src_data[s*DW +: DW]  = d;
   endtask

   task automatic idle_src();
      src_valid = '0;
      src_addr  = '0;
      src_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_src();
      rd_addr_a = '0;
      rd_addr_b = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int model_winner();
      for (int k = 0; k < NS; k++) begin
         int s;
         s = (m_turn + k) % NS;
         if (m_held[s]) return s;
      end
      return -1;
   endfunction

   function automatic int model_matches(input logic [AW-1:0] ra);
      int n;
      n = 0;
      if (ra == 0) return 0;
      for (int i = 0; i < NS; i++) if (m_held[i] && m_addr[i] == ra) n++;
      return n;
   endfunction

   function automatic logic [DW-1:0] model_match_data(input logic [AW-1:0] ra);
      for (int i = 0; i < NS; i++) if (m_held[i] && m_addr[i] == ra) return m_data[i];
      return '0;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_src();
      rd_addr_a = '0;
      rd_addr_b = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (rf_write_en !== 1'b0 || rf_write_addr !== '0 || rf_data_in !== '0)
         $display("FAIL reset_rf: got en=%b addr=%0d data=%h, want 0/0/0", rf_write_en, rf_write_addr, rf_data_in);
      else n_pass++;
      n_checks++;
      if (pending !== 2'd0 || src_ready !== 2'b11)
         $display("FAIL reset_state: got pending=%0d ready=%b, want 0 and 11", pending, src_ready);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      do_reset();
      drive_src(0, 1'b1, 5'd5, 64'hDEAD);
      #1;
      n_checks++;
      if (src_ready[0] !== 1'b1) $display("FAIL single_ready: got %b want 1", src_ready[0]);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      idle_src();
      #1;
      n_checks++;
      if (pending !== 2'd1 || rf_write_en !== 1'b0)
         $display("FAIL single_held: got pending=%0d en=%b, want 1 and 0", pending, rf_write_en);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_data_in !== 64'hDEAD || pending !== 2'd0)
         $display("FAIL single_issue: got en=%b addr=%0d data=%h pending=%0d, want 1/5/dead/0",
                  rf_write_en, rf_write_addr, rf_data_in, pending);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (rf_write_en !== 1'b0 || rf_write_addr !== 5'd5)
         $display("FAIL single_idle: got en=%b addr=%0d, want 0 and held addr 5", rf_write_en, rf_write_addr);
      else n_pass++;
   endtask

   task automatic test_alternate();
      do_reset();
      drive_src(0, 1'b1, 5'd3, 64'h11);
      drive_src(1, 1'b1, 5'd4, 64'h22);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (rf_write_en !== 1'b0 || src_ready !== 2'b01 || pending !== 2'd2)
         $display("FAIL alt_first: got en=%b ready=%b pending=%0d, want 0/01/2", rf_write_en, src_ready, pending);
      else n_pass++;
      for (int k = 1; k <= 6; k++) begin
         logic [AW-1:0] ea;
         logic [DW-1:0] ed;
         ea = (k % 2 == 1) ? 5'd3 : 5'd4;
         ed = (k % 2 == 1) ? 64'h11 : 64'h22;
         @(posedge clk);
         @(negedge clk);
         #1;
         n_checks++;
         if (rf_write_en !== 1'b1 || rf_write_addr !== ea || rf_data_in !== ed || src_ready[k % 2] !== 1'b1 || pending !== 2'd2)
            $display("FAIL alt_issue_%0d: got en=%b addr=%0d data=%h ready=%b pending=%0d, want 1/%0d/%h next-ready/2",
                     k, rf_write_en, rf_write_addr, rf_data_in, src_ready, pending, ea, ed);
         else n_pass++;
      end
      idle_src();
   endtask

   task automatic test_x0();
      do_reset();
      drive_src(1, 1'b1, 5'd0, 64'hFFFF);
      #1;
      n_checks++;
      if (src_ready[1] !== 1'b1) $display("FAIL x0_ready: got %b want 1", src_ready[1]);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      idle_src();
      #1;
      n_checks++;
      if (pending !== 2'd0 || rf_write_en !== 1'b0)
         $display("FAIL x0_held: got pending=%0d en=%b, want 0 and 0", pending, rf_write_en);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (pending !== 2'd0 || rf_write_en !== 1'b0)
         $display("FAIL x0_issue: got pending=%0d en=%b, want 0 and 0", pending, rf_write_en);
      else n_pass++;
   endtask

   task automatic test_hazard_single();
      do_reset();
      drive_src(0, 1'b1, 5'd1, 64'hAA);
      drive_src(1, 1'b1, 5'd7, 64'h77);
      rd_addr_a = 5'd7;
      @(posedge clk);
      @(negedge clk);
      idle_src();
      #1;
      n_checks++;
      if (src_ready[1] !== 1'b0 || pending !== 2'd2)
         $display("FAIL haz_blocked: got ready=%b pending=%0d, want src1 not ready and 2", src_ready, pending);
      else n_pass++;
      n_checks++;
`ifdef WB_BYPASS_EN
      if (hazard_a !== 1'b0 || fwd_valid_a !== 1'b1 || fwd_data_a !== 64'h77)
         $display("FAIL haz_fwd: got hazard=%b fwd_valid=%b fwd_data=%h, want 0/1/77", hazard_a, fwd_valid_a, fwd_data_a);
      else n_pass++;
`else
      if (hazard_a !== 1'b1 || fwd_valid_a !== 1'b0 || fwd_data_a !== '0)
         $display("FAIL haz_stall: got hazard=%b fwd_valid=%b fwd_data=%h, want 1/0/0", hazard_a, fwd_valid_a, fwd_data_a);
      else n_pass++;
`endif
      rd_addr_a = 5'd0;
      #1;
      n_checks++;
      if (hazard_a !== 1'b0 || fwd_valid_a !== 1'b0)
         $display("FAIL haz_x0: got hazard=%b fwd_valid=%b, want 0/0", hazard_a, fwd_valid_a);
      else n_pass++;
      rd_addr_a = 5'd7;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (hazard_a !== 1'b0 || fwd_valid_a !== 1'b0 || rf_write_addr !== 5'd7 || rf_data_in !== 64'h77)
         $display("FAIL haz_cleared: got hazard=%b fwd_valid=%b addr=%0d data=%h, want 0/0/7/77",
                  hazard_a, fwd_valid_a, rf_write_addr, rf_data_in);
      else n_pass++;
      rd_addr_a = '0;
   endtask

   task automatic test_hazard_double();
      do_reset();
      drive_src(0, 1'b1, 5'd9, 64'h1);
      drive_src(1, 1'b1, 5'd9, 64'h2);
      rd_addr_b = 5'd9;
      @(posedge clk);
      @(negedge clk);
      idle_src();
      #1;
      n_checks++;
      if (hazard_b !== 1'b1 || fwd_valid_b !== 1'b0)
         $display("FAIL dbl_hazard: got hazard=%b fwd_valid=%b, want 1/0", hazard_b, fwd_valid_b);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
`ifdef WB_BYPASS_EN
      if (hazard_b !== 1'b0 || fwd_valid_b !== 1'b1 || fwd_data_b !== 64'h2)
         $display("FAIL dbl_one_left: got hazard=%b fwd_valid=%b fwd_data=%h, want 0/1/2", hazard_b, fwd_valid_b, fwd_data_b);
      else n_pass++;
`else
      if (hazard_b !== 1'b1 || fwd_valid_b !== 1'b0)
         $display("FAIL dbl_one_left: got hazard=%b fwd_valid=%b, want 1/0", hazard_b, fwd_valid_b);
      else n_pass++;
`endif
      rd_addr_b = '0;
   endtask

   task automatic test_reset_drop();
      do_reset();
      drive_src(0, 1'b1, 5'd10, 64'hA0);
      drive_src(1, 1'b1, 5'd11, 64'hB0);
      @(posedge clk);
      @(negedge clk);
      idle_src();
      reset = 1'b1;
      #1;
      n_checks++;
      if (pending !== 2'd2) $display("FAIL drop_pre: got pending=%0d want 2", pending);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (pending !== 2'd0 || rf_write_en !== 1'b0)
         $display("FAIL drop_reset: got pending=%0d en=%b, want 0/0", pending, rf_write_en);
      else n_pass++;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         n_checks++;
         if (rf_write_en !== 1'b0 || pending !== 2'd0)
            $display("FAIL drop_after_%0d: got en=%b pending=%0d, want 0/0", k, rf_write_en, pending);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < NS; i++) begin
         m_held[i] = 0;
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      m_turn  = 0;
      m_en    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int w, na, nb;
         logic [NS-1:0] exp_ready;
         logic [PW-1:0] exp_pend;
         bit e_haz_a, e_haz_b, e_fv_a, e_fv_b;
         logic [DW-1:0] e_fd_a, e_fd_b;
         @(negedge clk);
         reset = ($urandom_range(0, 49) == 0);
         for (int s = 0; s < NS; s++)
            drive_src(s, ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), {$urandom, $urandom});
         rd_addr_a = 5'($urandom_range(0, 7));
         rd_addr_b = 5'($urandom_range(0, 7));
         #1;
         w = model_winner();
         exp_pend = '0;
         for (int s = 0; s < NS; s++) begin
            exp_ready[s] = !m_held[s] || (w == s);
            if (m_held[s]) exp_pend = exp_pend + 1'b1;
         end
         na = model_matches(rd_addr_a);
         nb = model_matches(rd_addr_b);
`ifdef WB_BYPASS_EN
         e_fv_a = (na == 1);  e_haz_a = (na >= 2);
         e_fv_b = (nb == 1);  e_haz_b = (nb >= 2);
         e_fd_a = e_fv_a ? model_match_data(rd_addr_a) : '0;
         e_fd_b = e_fv_b ? model_match_data(rd_addr_b) : '0;
`else
         e_fv_a = 0;  e_haz_a = (na >= 1);  e_fd_a = '0;
         e_fv_b = 0;  e_haz_b = (nb >= 1);  e_fd_b = '0;
`endif
         n_checks++;
         if (src_ready !== exp_ready || pending !== exp_pend)
            $display("FAIL rnd_ready_%0d: got ready=%b pending=%0d, want %b/%0d", cyc, src_ready, pending, exp_ready, exp_pend);
         else n_pass++;
         n_checks++;
         if (rf_write_en !== m_en || rf_write_addr !== m_waddr || rf_data_in !== m_wdata)
            $display("FAIL rnd_rf_%0d: got en=%b addr=%0d data=%h, want %b/%0d/%h",
                     cyc, rf_write_en, rf_write_addr, rf_data_in, m_en, m_waddr, m_wdata);
         else n_pass++;
         n_checks++;
         if (hazard_a !== e_haz_a || fwd_valid_a !== e_fv_a || fwd_data_a !== e_fd_a ||
             hazard_b !== e_haz_b || fwd_valid_b !== e_fv_b || fwd_data_b !== e_fd_b)
            $display("FAIL rnd_lookup_%0d: got a=%b/%b/%h b=%b/%b/%h, want a=%b/%b/%h b=%b/%b/%h", cyc,
                     hazard_a, fwd_valid_a, fwd_data_a, hazard_b, fwd_valid_b, fwd_data_b,
                     e_haz_a, e_fv_a, e_fd_a, e_haz_b, e_fv_b, e_fd_b);
         else n_pass++;
         @(posedge clk);
         if (reset) begin
            for (int s = 0; s < NS; s++) begin
               m_held[s] = 0;
               m_addr[s] = '0;
               m_data[s] = '0;
            end
            m_turn  = 0;
            m_en    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
         end else begin
            if (w >= 0) begin
               m_en      = 1'b1;
               m_waddr   = m_addr[w];
               m_wdata   = m_data[w];
               m_held[w] = 0;
               m_turn    = (w + 1) % NS;
            end else begin
               m_en = 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
               if (src_valid[s] && exp_ready[s] && src_addr[s*AW +: AW] != 0) begin
                  m_held[s] = 1;
                  m_addr[s] = src_addr[s*AW +: AW];
                  m_data[s] = src_data[s*DW +: DW];
               end
            end
         end
      end
      @(negedge clk);
      reset = 1'b0;
      idle_src();
   endtask

   initial begin
      reset     = 1'b1;
      src_valid = '0;
      src_addr  = '0;
      src_data  = '0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      test_reset();
      test_single_write();
      test_alternate();
      test_x0();
      test_hazard_single();
      test_hazard_double();
      test_reset_drop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
